// File: rtl/cosim_pkg.sv
// Shared types and LFSR helper for the golden-vs-netlist co-simulation sequencer.
package cosim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST1,
        REL1,
        RAND,
        RST2,
        REL2,
        DIR,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // Right-shifting Galois step: the bit shifted out feeds back through the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/cosim_lane_cmp.sv
// Per-lane equality check between golden and netlist outputs.
module cosim_lane_cmp #(
    parameter int WIDTH = 32,
    parameter int NCH   = 1
) (
    input  logic [NCH*WIDTH-1:0] golden,
    input  logic [NCH*WIDTH-1:0] netlist,
    output logic [NCH-1:0]       fail,
    output logic                 any_fail
);

    always_comb begin
        fail = '0;
        for (int k = 0; k < NCH; k++) begin
            fail[k] = golden[k*WIDTH +: WIDTH] != netlist[k*WIDTH +: WIDTH];
        end
    end

    assign any_fail = |fail;

endmodule

// File: rtl/cosim_selfcheck_sequencer.sv
// Stimulus sequencer and mismatch recorder for golden-vs-netlist co-simulation:
// reset test, N_RANDOM LFSR vectors, reset test, directed vector.
module cosim_selfcheck_sequencer
    import cosim_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          NCH      = 1,
    parameter int          N_RANDOM = 1000,
    parameter int          SETTLE   = 2,
    parameter logic [31:0] SEED     = 32'h1,
    parameter logic [31:0] DIRECTED = 32'habcdefab,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 dut_rst,
    output logic [WIDTH-1:0]     stim,
    input  logic [NCH*WIDTH-1:0] golden_out,
    input  logic [NCH*WIDTH-1:0] netlist_out,
    output logic                 cmp_strobe,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [NCH-1:0]       lane_fail,
    output logic [CNT_W-1:0]     first_idx,
    output logic                 first_valid
);

    localparam int SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The vector index must reach N_RANDOM+3 even when CNT_W is narrow.
    localparam int IDX_NEED = $clog2(N_RANDOM + 4);
    localparam int IDX_W    = (IDX_NEED > CNT_W) ? IDX_NEED : CNT_W;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_cnt;
    logic [IDX_W-1:0]   vec_idx;
    logic [31:0]        lfsr;
    logic               cmp_state;
    logic               start_acc;
    logic               load_slot;
    logic [NCH-1:0]     fail_vec;
    logic               any_fail;

    function automatic logic [WIDTH-1:0] replicate(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[i % 32];
        end
        return r;
    endfunction

    cosim_lane_cmp #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_lane_cmp (
        .golden   (golden_out),
        .netlist  (netlist_out),
        .fail     (fail_vec),
        .any_fail (any_fail)
    );

    assign cmp_state  = state_q inside {RST1, RAND, RST2, DIR};
    assign cmp_strobe = cmp_state && (settle_cnt == SET_W'(SETTLE - 1));
    assign start_acc  = start && (state_q inside {IDLE, DONE});
    assign dut_rst    = state_q inside {IDLE, RST1, RST2, DONE};
    assign busy       = !(state_q inside {IDLE, DONE});
    assign done       = state_q == DONE;
    assign pass       = done && (mismatch_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RST1;
            RST1:       if (cmp_strobe) state_d = REL1;
            REL1:       state_d = RAND;
            RAND:       if (cmp_strobe && vec_idx == IDX_W'(N_RANDOM)) state_d = RST2;
            RST2:       if (cmp_strobe) state_d = REL2;
            REL2:       state_d = DIR;
            DIR:        if (cmp_strobe) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // A new stimulus slot begins on entry to RAND/RST2/DIR and on every RAND compare.
    assign load_slot = (state_d inside {RAND, RST2, DIR}) && ((state_d != state_q) || cmp_strobe);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stim         <= '0;
            settle_cnt   <= '0;
            vec_idx      <= '0;
            lfsr         <= SEED;
            mismatch_cnt <= '0;
            lane_fail    <= '0;
            first_idx    <= '0;
            first_valid  <= 1'b0;
        end else if (start_acc) begin
            stim         <= '0;
            settle_cnt   <= '0;
            vec_idx      <= '0;
            lfsr         <= SEED;
            mismatch_cnt <= '0;
            lane_fail    <= '0;
            first_idx    <= '0;
            first_valid  <= 1'b0;
        end else begin
            if (cmp_strobe)     settle_cnt <= '0;
            else if (cmp_state) settle_cnt <= settle_cnt + 1'b1;

            if (load_slot) begin
                case (state_d)
                    RAND: begin
                        stim <= replicate(lfsr);
                        lfsr <= lfsr_step(lfsr);
                    end
                    DIR:     stim <= replicate(DIRECTED);
                    default: stim <= '0;
                endcase
            end

            if (cmp_strobe) begin
                vec_idx <= vec_idx + 1'b1;
                if (any_fail) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                    lane_fail <= lane_fail | fail_vec;
                    if (!first_valid) begin
                        first_valid <= 1'b1;
                        first_idx   <= CNT_W'(vec_idx);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cosim_selfcheck_sequencer.sv
// Directed bench for the co-simulation sequencer: two instances with small sequence lengths.
module tb_cosim_selfcheck_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: NCH=2, N_RANDOM=4, SETTLE=2, CNT_W=16
    logic        a_rst, a_start, a_dut_rst, a_cmp_strobe, a_busy, a_done, a_pass, a_first_valid;
    logic [31:0] a_stim;
    logic [63:0] a_golden, a_netlist;
    logic [15:0] a_mis, a_first_idx;
    logic [1:0]  a_lane_fail;
    logic        a_mode;

    // Instance B: NCH=2, N_RANDOM=20, SETTLE=2, CNT_W=4
    logic        b_rst, b_start, b_dut_rst, b_cmp_strobe, b_busy, b_done, b_pass, b_first_valid;
    logic [31:0] b_stim;
    logic [63:0] b_golden, b_netlist;
    logic [3:0]  b_mis, b_first_idx;
    logic [1:0]  b_lane_fail;
    logic        b_mode;

    assign a_golden  = {a_stim ^ 32'h5a5a5a5a, a_stim};
    assign a_netlist = a_golden ^ ((a_mode && a_stim == 32'habcdefab) ? {32'h1, 32'h0} : 64'h0);
    assign b_golden  = {b_stim ^ 32'h5a5a5a5a, b_stim};
    assign b_netlist = b_golden ^ (b_mode ? 64'h1 : 64'h0);

    cosim_selfcheck_sequencer #(
        .WIDTH(32), .NCH(2), .N_RANDOM(4), .SETTLE(2),
        .SEED(32'h1), .DIRECTED(32'habcdefab), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .dut_rst(a_dut_rst), .stim(a_stim),
        .golden_out(a_golden), .netlist_out(a_netlist), .cmp_strobe(a_cmp_strobe),
        .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch_cnt(a_mis),
        .lane_fail(a_lane_fail), .first_idx(a_first_idx), .first_valid(a_first_valid)
    );

    cosim_selfcheck_sequencer #(
        .WIDTH(32), .NCH(2), .N_RANDOM(20), .SETTLE(2),
        .SEED(32'h1), .DIRECTED(32'habcdefab), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .dut_rst(b_dut_rst), .stim(b_stim),
        .golden_out(b_golden), .netlist_out(b_netlist), .cmp_strobe(b_cmp_strobe),
        .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch_cnt(b_mis),
        .lane_fail(b_lane_fail), .first_idx(b_first_idx), .first_valid(b_first_valid)
    );

    // Stimulus seen on each compare strobe
    logic [31:0] a_log [64];
    logic [31:0] b_log [64];
    int a_n = 0;
    int b_n = 0;

    always @(negedge clk) begin
        if (a_cmp_strobe === 1'b1 && a_n < 64) begin
            a_log[a_n] = a_stim;
            a_n = a_n + 1;
        end
        if (b_cmp_strobe === 1'b1 && b_n < 64) begin
            b_log[b_n] = b_stim;
            b_n = b_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_a;
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic pulse_b;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
    endtask

    task automatic wait_a(input bit inject, output int cyc);
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 5) a_start = 1'b1;
            if (inject && cyc == 6) a_start = 1'b0;
        end
    endtask

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    logic [31:0] exp_a [7];
    logic [31:0] exp_b [23];

    initial begin
        int cyc;
        int k;
        int errs;
        logic [31:0] s;

        exp_a[0] = 32'h0;
        exp_a[1] = 32'h00000001;
        exp_a[2] = 32'h80200003;
        exp_a[3] = 32'hc0300002;
        exp_a[4] = 32'h60180001;
        exp_a[5] = 32'h0;
        exp_a[6] = 32'habcdefab;

        exp_b[0] = 32'h0;
        s = 32'h1;
        for (int i = 1; i <= 20; i++) begin
            exp_b[i] = s;
            s = model_step(s);
        end
        exp_b[21] = 32'h0;
        exp_b[22] = 32'habcdefab;

        a_rst = 1'b0; a_start = 1'b0; a_mode = 1'b0;
        b_rst = 1'b0; b_start = 1'b0; b_mode = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_dut_rst",     a_dut_rst,     1);
        check("rst_stim",        a_stim,        0);
        check("rst_busy",        a_busy,        0);
        check("rst_done",        a_done,        0);
        check("rst_mis",         a_mis,         0);
        check("rst_lane_fail",   a_lane_fail,   0);
        check("rst_first_valid", a_first_valid, 0);
        check("rst_strobe",      a_cmp_strobe,  0);

        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);

        // Clean loopback run, with a start pulse injected mid-sequence
        a_n = 0;
        pulse_a();
        check("t1_busy_after_start", a_busy,    1);
        check("t1_dut_rst_rst1",     a_dut_rst, 1);
        wait_a(1'b1, cyc);
        check("t1_done_latency", cyc,          16);
        check("t1_pass",         a_pass,       1);
        check("t1_mis",          a_mis,        0);
        check("t1_lane_fail",    a_lane_fail,  0);
        check("t1_busy_done",    a_busy,       0);
        check("t1_dut_rst_done", a_dut_rst,    1);
        check("t1_strobes",      a_n,          7);
        for (int i = 0; i < 7; i++) check($sformatf("t2_stim%0d", i), a_log[i], exp_a[i]);

        // Lane 1 fails only on the directed vector; restart from DONE
        a_mode = 1'b1;
        a_n = 0;
        pulse_a();
        wait_a(1'b0, cyc);
        check("t3_done_latency", cyc,           16);
        check("t3_mis",          a_mis,         1);
        check("t3_lane_fail",    a_lane_fail,   2'b10);
        check("t3_first_idx",    a_first_idx,   6);
        check("t3_first_valid",  a_first_valid, 1);
        check("t3_pass",         a_pass,        0);

        // Start from DONE clears the recorded statistics
        a_mode = 1'b0;
        pulse_a();
        check("t6_mis_clr",       a_mis,         0);
        check("t6_lane_fail_clr", a_lane_fail,   0);
        check("t6_first_clr",     a_first_valid, 0);
        check("t6_done_clr",      a_done,        0);
        check("t6_busy",          a_busy,        1);
        wait_a(1'b0, cyc);
        check("t6_pass", a_pass, 1);

        // Every compare fails: narrow counter saturates
        b_mode = 1'b1;
        pulse_b();
        wait_b(cyc);
        check("t4_done_latency", cyc,           48);
        check("t4_mis_sat",      b_mis,         15);
        check("t4_first_idx",    b_first_idx,   0);
        check("t4_first_valid",  b_first_valid, 1);
        check("t4_lane_fail",    b_lane_fail,   2'b01);
        check("t4_pass",         b_pass,        0);

        // Asynchronous reset while vector 10 is in flight
        b_n = 0;
        pulse_b();
        k = 0;
        while (b_n < 11 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t5_reached_vec10", b_n,    11);
        check("t5_mis_before",    b_mis,  10);
        check("t5_busy_before",   b_busy, 1);
        b_rst = 1'b0;
        #1;
        check("t5_dut_rst",     b_dut_rst,     1);
        check("t5_stim",        b_stim,        0);
        check("t5_busy",        b_busy,        0);
        check("t5_mis",         b_mis,         0);
        check("t5_first_valid", b_first_valid, 0);
        @(negedge clk);
        b_rst = 1'b1;
        b_mode = 1'b0;
        b_n = 0;
        pulse_b();
        wait_b(cyc);
        check("t5_done_latency", cyc,        48);
        check("t5_pass",         b_pass,     1);
        check("t5_strobes",      b_n,        23);
        check("t5_stim4",        b_log[4],   32'h60180001);
        check("t5_stim10",       b_log[10],  exp_b[10]);
        errs = 0;
        for (int i = 0; i < 23; i++) if (b_log[i] !== exp_b[i]) errs++;
        check("t5_replay_seq", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
